alarm_multi_trigger: RTL and testbench

- Parametrised successor of the single-slot alarm trigger condition: holds NUM_ALARMS programmable alarm slots (hour/min/sec plus enable) and compares each against the RTC time.
- A match raises the alarm. The alarm is then dismissed by pin_check, postponed by snooze, or auto-silenced after a timeout that pulses a "missed" flag.
- Sits between the RTC counter and the buzzer/display/PIN-entry logic.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_slot_cmp.sv | 52 +++++
 rtl/alarm_multi_trigger.sv | 163 ++++++++++++++++
 tb/tb_alarm_multi_trigger.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding, time field widths and slot record
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam int HOUR_W      = 5;
  localparam int MIN_W       = 6;
  localparam int SEC_W       = 6;
  localparam int MAX_HOUR    = 23;
  localparam int MAX_MIN_SEC = 59;

  typedef struct packed {
    logic              en;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } slot_t;

endpackage

// File: rtl/alarm_slot_cmp.sv
// rtl/alarm_slot_cmp.sv - one programmable alarm slot and its time comparator
module alarm_slot_cmp
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              en_in,
  input  logic [HOUR_W-1:0] hour_in,
  input  logic [MIN_W-1:0]  min_in,
  input  logic [SEC_W-1:0]  sec_in,
  input  logic [HOUR_W-1:0] hour_rtc,
  input  logic [MIN_W-1:0]  min_rtc,
  input  logic [SEC_W-1:0]  sec_rtc,
  output logic              en,
  output logic              match
);

  slot_t slot_q, slot_d;
  logic  time_valid;
  logic  time_equal;

  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      slot_d.en   = en_in;
      slot_d.hour = hour_in;
      slot_d.min  = min_in;
      slot_d.sec  = sec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Out-of-range times are kept as written but are barred from matching.
  assign time_valid = (slot_q.hour <= HOUR_W'(MAX_HOUR)) &&
                      (slot_q.min  <= MIN_W'(MAX_MIN_SEC)) &&
                      (slot_q.sec  <= SEC_W'(MAX_MIN_SEC));
  assign time_equal = (slot_q.hour == hour_rtc) &&
                      (slot_q.min  == min_rtc) &&
                      (slot_q.sec  == sec_rtc);

  assign en    = slot_q.en;
  assign match = slot_q.en && time_valid && time_equal;

endmodule

// File: rtl/alarm_multi_trigger.sv
// rtl/alarm_multi_trigger.sv - multi-slot alarm: slot compare, trigger priority,
// ring / snooze / timeout state machine
module alarm_multi_trigger
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int IDX_W       = 2,
  parameter int SNOOZE_SEC  = 300,
  parameter int TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HOUR_W-1:0]     hour_rtc,
  input  logic [MIN_W-1:0]      min_rtc,
  input  logic [SEC_W-1:0]      sec_rtc,
  input  logic                  alarm_set,
  input  logic [IDX_W-1:0]      alarm_idx_in,
  input  logic                  alarm_en_in,
  input  logic [HOUR_W-1:0]     alarm_hour_in,
  input  logic [MIN_W-1:0]      alarm_min_in,
  input  logic [SEC_W-1:0]      alarm_sec_in,
  input  logic                  pin_check,
  input  logic                  snooze,
  output logic                  alarm_active,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  snoozing,
  output logic                  missed,
  output logic [NUM_ALARMS-1:0] slot_en
);

  localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [7:0]       RING_LAST = 8'(TIMEOUT_SEC - 1);
  localparam logic [11:0]      SN_LOAD   = 12'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  logic [NUM_ALARMS-1:0] match, match_q, match_d, rise, en_vec;
  logic [SEC_W-1:0]      sec_q, sec_d;
  logic                  snooze_prev_q, snooze_prev_d;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, trig_idx;
  logic [7:0]            ring_cnt_q, ring_cnt_d;
  logic [11:0]           sn_cnt_q, sn_cnt_d;
  logic [SNZ_W-1:0]      snz_cnt_q, snz_cnt_d;
  logic                  missed_q, missed_d;
  logic                  trig_any, tick, snooze_req;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    alarm_slot_cmp u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (alarm_set && (alarm_idx_in == IDX_W'(g))),
      .en_in    (alarm_en_in),
      .hour_in  (alarm_hour_in),
      .min_in   (alarm_min_in),
      .sec_in   (alarm_sec_in),
      .hour_rtc (hour_rtc),
      .min_rtc  (min_rtc),
      .sec_rtc  (sec_rtc),
      .en       (en_vec[g]),
      .match    (match[g])
    );
  end

  assign tick       = (sec_rtc != sec_q);
  assign rise       = match & ~match_q;
  assign snooze_req = snooze & ~snooze_prev_q;

  // Scan from the top so the lowest-index rising slot is the one kept.
  always_comb begin
    trig_idx = '0;
    trig_any = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        trig_idx = IDX_W'(i);
        trig_any = 1'b1;
      end
    end
  end

  always_comb begin
    sec_d         = sec_rtc;
    match_d       = match;
    snooze_prev_d = snooze;
    state_d       = state_q;
    idx_d         = idx_q;
    ring_cnt_d    = ring_cnt_q;
    sn_cnt_d      = sn_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    missed_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_any) begin
          state_d    = ST_RING;
          idx_d      = trig_idx;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      end
      ST_RING: begin
        if (pin_check) begin
          state_d = ST_IDLE;
        end else if (snooze_req && (snz_cnt_q < SNZ_MAX)) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = snz_cnt_q + 1'b1;
          sn_cnt_d  = SN_LOAD;
        end else if (tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d  = ST_IDLE;
            missed_d = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (pin_check) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sn_cnt_q <= 12'd1) begin
            state_d    = ST_RING;
            sn_cnt_d   = '0;
            ring_cnt_d = '0;
          end else begin
            sn_cnt_d = sn_cnt_q - 12'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q         <= '0;
      match_q       <= '0;
      snooze_prev_q <= 1'b0;
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      ring_cnt_q    <= '0;
      sn_cnt_q      <= '0;
      snz_cnt_q     <= '0;
      missed_q      <= 1'b0;
    end else begin
      sec_q         <= sec_d;
      match_q       <= match_d;
      snooze_prev_q <= snooze_prev_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      ring_cnt_q    <= ring_cnt_d;
      sn_cnt_q      <= sn_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      missed_q      <= missed_d;
    end
  end

  assign alarm_active = (state_q == ST_RING);
  assign snoozing     = (state_q == ST_SNOOZE);
  assign active_idx   = idx_q;
  assign missed       = missed_q;
  assign slot_en      = en_vec;

endmodule

// File: tb/tb_alarm_multi_trigger.sv
// tb/tb_alarm_multi_trigger.sv - directed stimulus with a queued-expectation scoreboard
module tb_alarm_multi_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hour_rtc = '0;
  logic [5:0] min_rtc = '0;
  logic [5:0] sec_rtc = '0;
  logic       alarm_set = 1'b0;
  logic [1:0] alarm_idx_in = '0;
  logic       alarm_en_in = 1'b0;
  logic [4:0] alarm_hour_in = '0;
  logic [5:0] alarm_min_in = '0;
  logic [5:0] alarm_sec_in = '0;
  logic       pin_check = 1'b0;
  logic       snooze = 1'b0;
  logic       alarm_active;
  logic [1:0] active_idx;
  logic       snoozing;
  logic       missed;
  logic [3:0] slot_en;

  always #5 clk = ~clk;

  alarm_multi_trigger #(
    .NUM_ALARMS (4),
    .IDX_W      (2),
    .SNOOZE_SEC (3),
    .TIMEOUT_SEC(5),
    .MAX_SNOOZE (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hour_rtc     (hour_rtc),
    .min_rtc      (min_rtc),
    .sec_rtc      (sec_rtc),
    .alarm_set    (alarm_set),
    .alarm_idx_in (alarm_idx_in),
    .alarm_en_in  (alarm_en_in),
    .alarm_hour_in(alarm_hour_in),
    .alarm_min_in (alarm_min_in),
    .alarm_sec_in (alarm_sec_in),
    .pin_check    (pin_check),
    .snooze       (snooze),
    .alarm_active (alarm_active),
    .active_idx   (active_idx),
    .snoozing     (snoozing),
    .missed       (missed),
    .slot_en      (slot_en)
  );

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         sec_v = 10;
  logic       m_aa = 1'b0;
  logic [1:0] m_idx = '0;
  logic       m_sn = 1'b0;
  logic       m_ms = 1'b0;
  logic [3:0] m_en = '0;
  logic [8:0] last_v = '0;
  logic       have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the output bundle must match the next queued expectation.
  always @(negedge clk) begin : monitor
    logic [8:0] v;
    exp_t       e;
    v = {alarm_active, active_idx, snoozing, missed, slot_en};
    if (!have_last || v !== last_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d actual=%h required=no_change", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.v !== v || e.cyc != cyc) begin
          failures++;
          $display("FAIL out_change cyc=%0d actual=%h required=%h at cyc=%0d", cyc, v, e.v, e.cyc);
        end
      end
      last_v    = v;
      have_last = 1'b1;
    end
  end

  task automatic push();
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = {m_aa, m_idx, m_sn, m_ms, m_en};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour_rtc = 5'(h);
    min_rtc  = 6'(m);
    sec_rtc  = 6'(s);
  endtask

  task automatic tick_rtc();
    sec_v = sec_v + 1;
    set_time(10, 0, sec_v);
  endtask

  task automatic write_slot(input int idx, input logic en, input int h, input int m, input int s);
    alarm_set     = 1'b1;
    alarm_idx_in  = 2'(idx);
    alarm_en_in   = en;
    alarm_hour_in = 5'(h);
    alarm_min_in  = 6'(m);
    alarm_sec_in  = 6'(s);
    if (m_en[idx] != en) begin
      m_en[idx] = en;
      push();
    end
    step();
    alarm_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    push();
    step();
    step();
    rst = 1'b0;

    // single slot trigger, dismissal, no retrigger on a held time
    write_slot(1, 1'b1, 1, 2, 3);
    set_time(1, 2, 2); step();
    set_time(1, 2, 3); m_aa = 1'b1; m_idx = 2'd1; push(); step();
    pin_check = 1'b1; m_aa = 1'b0; push(); step(); pin_check = 1'b0;
    repeat (10) step();

    // pin_check beats a simultaneous snooze
    tick_rtc(); step();
    set_time(1, 2, 3); m_aa = 1'b1; push(); step();
    pin_check = 1'b1; snooze = 1'b1; m_aa = 1'b0; push(); step();
    pin_check = 1'b0; snooze = 1'b0; step();

    // three snoozes of three ticks each, fourth ignored, then timeout
    tick_rtc(); step();
    set_time(1, 2, 3); m_aa = 1'b1; push(); step();
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1; m_aa = 1'b0; m_sn = 1'b1; push(); step(); snooze = 1'b0;
      tick_rtc(); step();
      tick_rtc(); step();
      tick_rtc(); m_aa = 1'b1; m_sn = 1'b0; push(); step();
    end
    snooze = 1'b1; step(); snooze = 1'b0; step();
    for (int k = 0; k < 4; k++) begin
      tick_rtc(); step();
    end
    tick_rtc(); m_aa = 1'b0; m_ms = 1'b1; push(); step();
    m_ms = 1'b0; push(); step();

    // simultaneous slots: lowest index wins, then disable it
    write_slot(0, 1'b1, 0, 0, 5);
    write_slot(2, 1'b1, 0, 0, 5);
    set_time(0, 0, 5); m_aa = 1'b1; m_idx = 2'd0; push(); step();
    pin_check = 1'b1; m_aa = 1'b0; push(); step(); pin_check = 1'b0;
    write_slot(0, 1'b0, 0, 0, 5);
    tick_rtc(); step();
    set_time(0, 0, 5); m_aa = 1'b1; m_idx = 2'd2; push(); step();

    // reset while ringing, then while snoozing
    rst = 1'b1; m_aa = 1'b0; m_idx = 2'd0; m_en = '0; push(); step(); rst = 1'b0;
    write_slot(3, 1'b1, 0, 0, 6);
    set_time(0, 0, 6); m_aa = 1'b1; m_idx = 2'd3; push(); step();
    snooze = 1'b1; m_aa = 1'b0; m_sn = 1'b1; push(); step(); snooze = 1'b0;
    rst = 1'b1; m_sn = 1'b0; m_idx = 2'd0; m_en = '0; push(); step(); rst = 1'b0;

    // out-of-range slot time is stored but never rings
    write_slot(0, 1'b1, 24, 0, 0);
    set_time(24, 0, 0); step(); step();
    set_time(0, 0, 0); step();
    repeat (3) step();

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_change cyc=%0d actual=none required=%h at cyc=%0d", cyc, e.v, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
